spi_mem_ctrl: RTL and testbench

Memory-side responder for the CPU controller's memory request interface. It accepts MEM_READ/MEM_WRITE requests on `mem_ctrl_op` and serves each as one SPI transaction to an external serial SRAM (23LC-style, mode 0, READ 0x03 / WRITE 0x02, 16-bit address). It returns the read byte and a one-cycle `mem_op_done` pulse. It sits between the address register/ALU datapath and the chip pins.

---
 rtl/spi_mem_ctrl.sv | 113 +++++++++++
 tb/tb_spi_mem_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_ctrl.sv
// SPI serial-SRAM responder for the CPU memory request interface.
// Each request becomes one 32-bit mode-0 frame: cmd, 16-bit address, data.
package spi_mem_pkg;
    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } mem_ctrl_op_e;
endpackage

module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  mem_ctrl_op_e              mem_ctrl_op,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_BUS_WIDTH-1:0] data_in,
    output logic [DATA_BUS_WIDTH-1:0] data_out,
    output logic                      mem_op_done,
    output logic                      spi_cs_n,
    output logic                      spi_sclk,
    output logic                      spi_mosi,
    input  logic                      spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        FINISH,
        RECOVER0,
        RECOVER1
    } state_e;

    state_e      state;
    logic [31:0] frame;
    logic [4:0]  bit_cnt;
    logic        high;
    logic        is_read;

    logic [15:0] addr16;
    logic        req_rd;
    logic        req_wr;
    logic [7:0]  cmd;
    logic [7:0]  wdata;

    assign addr16 = 16'(addr);
    assign req_rd = (mem_ctrl_op == MEM_READ);
    assign req_wr = (mem_ctrl_op == MEM_WRITE);
    assign cmd    = req_rd ? 8'h03 : 8'h02;
    assign wdata  = req_wr ? data_in : 8'h00;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            frame       <= '0;
            bit_cnt     <= '0;
            high        <= 1'b0;
            is_read     <= 1'b0;
            data_out    <= '0;
            mem_op_done <= 1'b0;
            spi_cs_n    <= 1'b1;
            spi_sclk    <= 1'b0;
            spi_mosi    <= 1'b0;
        end else begin
            mem_op_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        frame    <= {cmd, addr16, wdata};
                        is_read  <= req_rd;
                        bit_cnt  <= '0;
                        high     <= 1'b0;
                        spi_cs_n <= 1'b0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= cmd[7];
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!high) begin
                        spi_sclk <= 1'b1;
                        high     <= 1'b1;
                    end else begin
                        // falling edge: capture miso, present next MSB
                        high     <= 1'b0;
                        spi_sclk <= 1'b0;
                        frame    <= {frame[30:0], spi_miso};
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            state       <= FINISH;
                            spi_cs_n    <= 1'b1;
                            spi_mosi    <= 1'b0;
                            mem_op_done <= 1'b1;
                            if (is_read)
                                data_out <= {frame[6:0], spi_miso};
                        end else begin
                            spi_mosi <= frame[30];
                        end
                    end
                end
                FINISH:   state <= RECOVER0;
                RECOVER0: state <= RECOVER1;
                RECOVER1: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench for spi_mem_ctrl with a small serial SRAM model.
module tb_spi_mem_ctrl;
    import spi_mem_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    mem_ctrl_op_e op;
    logic [15:0]  addr;
    logic [7:0]   data_in;
    logic [7:0]   data_out;
    logic         mem_op_done;
    logic         spi_cs_n;
    logic         spi_sclk;
    logic         spi_mosi;
    logic         spi_miso = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] frame;
        int          done_cyc;
        string       name;
    } exp_t;
    exp_t q[$];

    logic [31:0] cap = '0;
    int          pulses = 0;
    logic [7:0]  sram_byte = 8'h00;
    logic        prev_done = 1'b0;

    spi_mem_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .mem_ctrl_op (op),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .mem_op_done (mem_op_done),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM side: mosi shifted in on sclk rise; cs_n fall starts a frame
    always @(negedge spi_cs_n or posedge spi_sclk) begin
        if (spi_sclk) begin
            cap = {cap[30:0], spi_mosi};
            pulses++;
        end else begin
            cap = '0;
            pulses = 0;
        end
    end

    // data byte driven after each fall for bits 24..31
    always @(negedge spi_sclk) begin
        int k;
        #1;
        k = pulses;
        spi_miso = (k >= 24 && k <= 31) ? sram_byte[31-k] : 1'b0;
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset === 1'b1 && mem_op_done === 1'b1) begin
            check("done_consecutive", 32'(prev_done), 0);
            if (q.size() == 0) begin
                check("unexpected_done", 32'(q.size()), 1);
            end else begin
                e = q.pop_front();
                check({e.name, "_data"}, 32'(data_out), 32'(e.data));
                check({e.name, "_mosi"}, cap, e.frame);
                check({e.name, "_pulses"}, 32'(pulses), 32);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.done_cyc));
            end
        end
        prev_done = mem_op_done;
    end

    task automatic issue(input mem_ctrl_op_e o, input logic [15:0] a,
                         input logic [7:0] d, input logic [7:0] ed,
                         input logic [31:0] ef, input string nm);
        exp_t e;
        op = o;
        addr = a;
        data_in = d;
        e.data = ed;
        e.frame = ef;
        e.done_cyc = cyc + 65;
        e.name = nm;
        q.push_back(e);
        @(negedge clock);
        op = MEM_NOP;
        addr = 16'hDEAD;
        data_in = 8'hFF;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check({name, "_timeout"}, 32'(q.size()), 0);
        repeat (4) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int csl;
        reset = 1'b0;
        op = MEM_READ;
        addr = 16'h0000;
        data_in = 8'h00;
        repeat (3) begin
            @(negedge clock);
            check("reset_pins",
                  {spi_cs_n, spi_sclk, spi_mosi, mem_op_done, data_out},
                  {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end
        op = MEM_NOP;
        reset = 1'b1;
        repeat (2) @(negedge clock);

        sram_byte = 8'h3C;
        issue(MEM_READ, 16'h00FF, 8'h77, 8'h3C, 32'h0300FF00, "read");
        drain("read");
        check("read_hold", 32'(data_out), 32'h3C);

        issue(MEM_WRITE, 16'h1234, 8'hA5, 8'h3C, 32'h021234A5, "write");
        drain("write");
        check("write_keeps_data", 32'(data_out), 32'h3C);

        begin
            exp_t e;
            int c0;
            c0 = cyc;
            op = MEM_READ;
            addr = 16'h0010;
            sram_byte = 8'h81;
            e.data = 8'h81; e.frame = 32'h03001000;
            e.done_cyc = c0 + 65; e.name = "b2b_first";
            q.push_back(e);
            e.data = 8'h7E; e.frame = 32'h03001100;
            e.done_cyc = c0 + 68 + 65; e.name = "b2b_second";
            q.push_back(e);
            repeat (65) @(negedge clock);
            check("b2b_cs_c65", 32'(spi_cs_n), 1);
            @(negedge clock);
            addr = 16'h0011;
            sram_byte = 8'h7E;
            check("b2b_cs_c66", 32'(spi_cs_n), 1);
            @(negedge clock);
            check("b2b_cs_c67", 32'(spi_cs_n), 1);
            @(negedge clock);
            check("b2b_cs_c68", 32'(spi_cs_n), 1);
            @(negedge clock);
            check("b2b_cs_c69", 32'(spi_cs_n), 0);
            op = MEM_NOP;
            addr = 16'hDEAD;
            drain("b2b");
        end

        op = MEM_WRITE;
        addr = 16'h1234;
        data_in = 8'hA5;
        @(negedge clock);
        op = MEM_NOP;
        repeat (19) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_pins",
              {spi_cs_n, spi_sclk, spi_mosi, mem_op_done, data_out},
              {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        repeat (2) @(negedge clock);
        reset = 1'b1;
        p0 = pulses;
        csl = 0;
        repeat (10) begin
            @(negedge clock);
            if (spi_cs_n !== 1'b1) csl++;
        end
        check("abort_sclk_edges", 32'(pulses - p0), 0);
        check("abort_cs_low", 32'(csl), 0);

        issue(MEM_WRITE, 16'hBEEF, 8'h5A, 8'h00, 32'h02BEEF5A, "post_reset");
        drain("post_reset");

        p0 = pulses;
        csl = 0;
        repeat (100) begin
            @(negedge clock);
            if (spi_cs_n !== 1'b1) csl++;
        end
        op = mem_ctrl_op_e'(2'b11);
        repeat (20) begin
            @(negedge clock);
            if (spi_cs_n !== 1'b1) csl++;
        end
        op = MEM_NOP;
        check("idle_sclk_edges", 32'(pulses - p0), 0);
        check("idle_cs_low", 32'(csl), 0);

        repeat (5) @(negedge clock);
        check("queue_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
